// File: rtl/llc_buf_fill.sv
// LLC set-buffer fill engine: snapshots one localmem set read and replays it one way per cycle.
// Optional build macro LLC_FILL_SCRUB_INVALID_EN zeroes the payload of ways whose state is INVALID.
module llc_buf_fill #(
  parameter int unsigned WAYS        = 16,
  parameter int unsigned WAY_BITS    = 4,
  parameter int unsigned LINE_BITS   = 128,
  parameter int unsigned TAG_BITS    = 16,
  parameter int unsigned STATE_BITS  = 3,
  parameter int unsigned OWNER_BITS  = 4,
  parameter int unsigned SHARER_BITS = 16,
  parameter int unsigned HPROT_BITS  = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rst_state,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic                        req_look,
  input  logic [WAYS*LINE_BITS-1:0]   rd_data_line_flat,
  input  logic [WAYS*TAG_BITS-1:0]    rd_data_tag_flat,
  input  logic [WAYS*STATE_BITS-1:0]  rd_data_state_flat,
  input  logic [WAYS*OWNER_BITS-1:0]  rd_data_owner_flat,
  input  logic [WAYS*SHARER_BITS-1:0] rd_data_sharers_flat,
  input  logic [WAYS*HPROT_BITS-1:0]  rd_data_hprot_flat,
  input  logic [WAYS-1:0]             rd_data_dirty_flat,
  input  logic [WAY_BITS-1:0]         rd_data_evict_way,
  output logic                        wr_en_buf,
  output logic [WAY_BITS-1:0]         way,
  output logic [LINE_BITS-1:0]        line_wr_data,
  output logic [TAG_BITS-1:0]         tag_wr_data,
  output logic [STATE_BITS-1:0]       state_wr_data,
  output logic [OWNER_BITS-1:0]       owner_wr_data,
  output logic [SHARER_BITS-1:0]      sharers_wr_data,
  output logic [HPROT_BITS-1:0]       hprot_wr_data,
  output logic                        dirty_wr_data,
  output logic                        evict_way_wr_en,
  output logic [WAY_BITS-1:0]         evict_way_wr_data,
  input  logic                        fifo_full_lookup,
  output logic                        fifo_push_lookup,
  input  logic                        fifo_full_proc,
  output logic                        fifo_push_proc,
  output logic                        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    PUSH = 2'd2
  } state_t;

  state_t              state;
  logic [WAY_BITS-1:0] cnt;
  logic [WAY_BITS-1:0] cnt_inc;
  logic                accept;
  logic                filling;
  logic                push_ok;
  logic                scrub;

  logic [LINE_BITS-1:0]   rd_line    [WAYS];
  logic [TAG_BITS-1:0]    rd_tag     [WAYS];
  logic [STATE_BITS-1:0]  rd_state   [WAYS];
  logic [OWNER_BITS-1:0]  rd_owner   [WAYS];
  logic [SHARER_BITS-1:0] rd_sharers [WAYS];
  logic [HPROT_BITS-1:0]  rd_hprot   [WAYS];
  logic                   rd_dirty   [WAYS];

  logic [LINE_BITS-1:0]   snap_line    [WAYS];
  logic [TAG_BITS-1:0]    snap_tag     [WAYS];
  logic [STATE_BITS-1:0]  snap_state   [WAYS];
  logic [OWNER_BITS-1:0]  snap_owner   [WAYS];
  logic [SHARER_BITS-1:0] snap_sharers [WAYS];
  logic [HPROT_BITS-1:0]  snap_hprot   [WAYS];
  logic                   snap_dirty   [WAYS];
  logic [WAY_BITS-1:0]    snap_evict;

  // Unpack the flat localmem read buses into per-way arrays
  for (genvar g = 0; g < WAYS; g++) begin : g_unpack
    assign rd_line[g]    = rd_data_line_flat[g*LINE_BITS +: LINE_BITS];
    assign rd_tag[g]     = rd_data_tag_flat[g*TAG_BITS +: TAG_BITS];
    assign rd_state[g]   = rd_data_state_flat[g*STATE_BITS +: STATE_BITS];
    assign rd_owner[g]   = rd_data_owner_flat[g*OWNER_BITS +: OWNER_BITS];
    assign rd_sharers[g] = rd_data_sharers_flat[g*SHARER_BITS +: SHARER_BITS];
    assign rd_hprot[g]   = rd_data_hprot_flat[g*HPROT_BITS +: HPROT_BITS];
    assign rd_dirty[g]   = rd_data_dirty_flat[g];
  end

  assign cnt_inc = cnt + WAY_BITS'(1);
  assign accept  = rst && (state == IDLE) && req_valid && !rst_state;

  // FSM, way counter and snapshot registers; the counter wrap ends FILL
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      cnt          <= '0;
      snap_evict   <= '0;
      snap_line    <= '{default: '0};
      snap_tag     <= '{default: '0};
      snap_state   <= '{default: '0};
      snap_owner   <= '{default: '0};
      snap_sharers <= '{default: '0};
      snap_hprot   <= '{default: '0};
      snap_dirty   <= '{default: 1'b0};
    end else if (rst_state) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (req_look) begin
              state        <= FILL;
              cnt          <= '0;
              snap_evict   <= rd_data_evict_way;
              snap_line    <= rd_line;
              snap_tag     <= rd_tag;
              snap_state   <= rd_state;
              snap_owner   <= rd_owner;
              snap_sharers <= rd_sharers;
              snap_hprot   <= rd_hprot;
              snap_dirty   <= rd_dirty;
            end else begin
              state <= PUSH;
            end
          end
        end
        FILL: begin
          cnt <= cnt_inc;
          if (cnt_inc == '0) begin
            state <= PUSH;
          end
        end
        PUSH: begin
          if (!fifo_full_lookup && !fifo_full_proc) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode the registered state; rst_state kills them in the same cycle
  assign filling          = (state == FILL) && !rst_state;
  assign push_ok          = (state == PUSH) && !rst_state && !fifo_full_lookup && !fifo_full_proc;
  assign req_ready        = accept;
  assign busy             = (state != IDLE);
  assign wr_en_buf        = filling;
  assign way              = cnt;
  assign evict_way_wr_en  = filling && (cnt == '0);
  assign evict_way_wr_data = snap_evict;
  assign fifo_push_lookup = push_ok;
  assign fifo_push_proc   = push_ok;

`ifdef LLC_FILL_SCRUB_INVALID_EN
  assign scrub = (snap_state[cnt] == '0);
`else
  assign scrub = 1'b0;
`endif

  // Write data always follows the current way slice
  assign line_wr_data    = scrub ? '0 : snap_line[cnt];
  assign tag_wr_data     = scrub ? '0 : snap_tag[cnt];
  assign state_wr_data   = snap_state[cnt];
  assign owner_wr_data   = scrub ? '0 : snap_owner[cnt];
  assign sharers_wr_data = scrub ? '0 : snap_sharers[cnt];
  assign hprot_wr_data   = scrub ? '0 : snap_hprot[cnt];
  assign dirty_wr_data   = scrub ? 1'b0 : snap_dirty[cnt];

endmodule

// File: tb/tb_llc_buf_fill.sv
// Directed self-checking bench for llc_buf_fill with a 4-way configuration.
module tb_llc_buf_fill;

  localparam int unsigned WAYS        = 4;
  localparam int unsigned WAY_BITS    = 2;
  localparam int unsigned LINE_BITS   = 128;
  localparam int unsigned TAG_BITS    = 16;
  localparam int unsigned STATE_BITS  = 3;
  localparam int unsigned OWNER_BITS  = 4;
  localparam int unsigned SHARER_BITS = 16;
  localparam int unsigned HPROT_BITS  = 1;
  localparam int unsigned LW = WAYS*LINE_BITS;
  localparam int unsigned TW = WAYS*TAG_BITS;
  localparam int unsigned SW = WAYS*STATE_BITS;
  localparam int unsigned OW = WAYS*OWNER_BITS;
  localparam int unsigned HW = WAYS*SHARER_BITS;
`ifdef LLC_FILL_SCRUB_INVALID_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, rst_state, req_valid, req_ready, req_look;
  logic [LW-1:0] line_flat;
  logic [TW-1:0] tag_flat;
  logic [SW-1:0] state_flat;
  logic [OW-1:0] owner_flat;
  logic [HW-1:0] sharers_flat;
  logic [WAYS*HPROT_BITS-1:0] hprot_flat;
  logic [WAYS-1:0] dirty_flat;
  logic [WAY_BITS-1:0] evict_in;
  logic wr_en_buf, dirty_wr_data, evict_way_wr_en;
  logic [WAY_BITS-1:0] way, evict_way_wr_data;
  logic [LINE_BITS-1:0] line_wr_data;
  logic [TAG_BITS-1:0] tag_wr_data;
  logic [STATE_BITS-1:0] state_wr_data;
  logic [OWNER_BITS-1:0] owner_wr_data;
  logic [SHARER_BITS-1:0] sharers_wr_data;
  logic [HPROT_BITS-1:0] hprot_wr_data;
  logic fifo_full_lookup, fifo_push_lookup, fifo_full_proc, fifo_push_proc, busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  llc_buf_fill #(
    .WAYS(WAYS), .WAY_BITS(WAY_BITS), .LINE_BITS(LINE_BITS), .TAG_BITS(TAG_BITS),
    .STATE_BITS(STATE_BITS), .OWNER_BITS(OWNER_BITS), .SHARER_BITS(SHARER_BITS),
    .HPROT_BITS(HPROT_BITS)
  ) dut (
    .clk(clk), .rst(rst), .rst_state(rst_state),
    .req_valid(req_valid), .req_ready(req_ready), .req_look(req_look),
    .rd_data_line_flat(line_flat), .rd_data_tag_flat(tag_flat),
    .rd_data_state_flat(state_flat), .rd_data_owner_flat(owner_flat),
    .rd_data_sharers_flat(sharers_flat), .rd_data_hprot_flat(hprot_flat),
    .rd_data_dirty_flat(dirty_flat), .rd_data_evict_way(evict_in),
    .wr_en_buf(wr_en_buf), .way(way),
    .line_wr_data(line_wr_data), .tag_wr_data(tag_wr_data), .state_wr_data(state_wr_data),
    .owner_wr_data(owner_wr_data), .sharers_wr_data(sharers_wr_data),
    .hprot_wr_data(hprot_wr_data), .dirty_wr_data(dirty_wr_data),
    .evict_way_wr_en(evict_way_wr_en), .evict_way_wr_data(evict_way_wr_data),
    .fifo_full_lookup(fifo_full_lookup), .fifo_push_lookup(fifo_push_lookup),
    .fifo_full_proc(fifo_full_proc), .fifo_push_proc(fifo_push_proc),
    .busy(busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Way i: line=0x100+i, tag=i+1, state=i, owner=i+8, sharers=1<<i, hprot=i[1], dirty=i[0]
  task automatic set_pattern();
    line_flat = '0; tag_flat = '0; state_flat = '0; owner_flat = '0; sharers_flat = '0;
    for (int i = 0; i < int'(WAYS); i++) begin
      line_flat    = line_flat    | (LW'(32'h100 + i) << (i*LINE_BITS));
      tag_flat     = tag_flat     | (TW'(i + 1) << (i*TAG_BITS));
      state_flat   = state_flat   | (SW'(i) << (i*STATE_BITS));
      owner_flat   = owner_flat   | (OW'(i + 8) << (i*OWNER_BITS));
      sharers_flat = sharers_flat | (HW'(1 << i) << (i*SHARER_BITS));
    end
    hprot_flat = 4'b1100;
    dirty_flat = 4'b1010;
    evict_in   = 2'd2;
  endtask

  task automatic corrupt_inputs();
    line_flat = '1; tag_flat = '1; state_flat = '1; owner_flat = '1; sharers_flat = '1;
    hprot_flat = '1; dirty_flat = '1; evict_in = 2'd1;
  endtask

  task automatic test_reset();
    rst = 1'b0; rst_state = 1'b0; req_valid = 1'b1; req_look = 1'b1;
    fifo_full_lookup = 1'b0; fifo_full_proc = 1'b0;
    set_pattern();
    #2;
    n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_ready got %b want 0", req_ready); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if ({wr_en_buf, evict_way_wr_en, fifo_push_lookup, fifo_push_proc} !== 4'b0)
      $display("FAIL reset_strobes got %b want 0000", {wr_en_buf, evict_way_wr_en, fifo_push_lookup, fifo_push_proc}); else n_pass++;
    n_checks++; if ({line_wr_data, tag_wr_data, way} !== '0) $display("FAIL reset_data got %h/%h/%h want 0", line_wr_data, tag_wr_data, way); else n_pass++;
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_fill();
    logic [LINE_BITS-1:0] e_line;
    logic [TAG_BITS-1:0] e_tag;
    logic [SHARER_BITS-1:0] e_sh;
    logic e_dirty;
    set_pattern();
    cyc(); req_valid = 1'b1; req_look = 1'b1;
    smp();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL fill_accept_ready got %b want 1", req_ready); else n_pass++;
    for (int w = 0; w < int'(WAYS); w++) begin
      cyc();
      if (w == 0) corrupt_inputs();
      smp();
      e_line  = (SCRUB && w == 0) ? '0 : LINE_BITS'(32'h100 + w);
      e_tag   = (SCRUB && w == 0) ? '0 : TAG_BITS'(w + 1);
      e_sh    = (SCRUB && w == 0) ? '0 : SHARER_BITS'(1 << w);
      e_dirty = (SCRUB && w == 0) ? 1'b0 : 1'(w % 2);
      n_checks++; if (wr_en_buf !== 1'b1) $display("FAIL fill_wr_en w%0d got %b want 1", w, wr_en_buf); else n_pass++;
      n_checks++; if (way !== WAY_BITS'(w)) $display("FAIL fill_way w%0d got %0d want %0d", w, way, w); else n_pass++;
      n_checks++; if (line_wr_data !== e_line) $display("FAIL fill_line w%0d got %h want %h", w, line_wr_data, e_line); else n_pass++;
      n_checks++; if (tag_wr_data !== e_tag) $display("FAIL fill_tag w%0d got %h want %h", w, tag_wr_data, e_tag); else n_pass++;
      n_checks++; if (state_wr_data !== STATE_BITS'(w)) $display("FAIL fill_state w%0d got %0d want %0d", w, state_wr_data, w); else n_pass++;
      n_checks++; if (sharers_wr_data !== e_sh) $display("FAIL fill_sharers w%0d got %h want %h", w, sharers_wr_data, e_sh); else n_pass++;
      n_checks++; if (dirty_wr_data !== e_dirty) $display("FAIL fill_dirty w%0d got %b want %b", w, dirty_wr_data, e_dirty); else n_pass++;
      n_checks++; if (evict_way_wr_en !== (w == 0)) $display("FAIL fill_evict_en w%0d got %b want %b", w, evict_way_wr_en, w == 0); else n_pass++;
      n_checks++; if ({fifo_push_lookup, fifo_push_proc, req_ready} !== 3'b0)
        $display("FAIL fill_no_push w%0d got %b want 000", w, {fifo_push_lookup, fifo_push_proc, req_ready}); else n_pass++;
      if (w == 0) begin
        n_checks++; if (evict_way_wr_data !== 2'd2) $display("FAIL fill_evict_data got %0d want 2", evict_way_wr_data); else n_pass++;
      end
    end
    cyc(); req_valid = 1'b0;
    smp();
    n_checks++; if ({fifo_push_lookup, fifo_push_proc, wr_en_buf, busy} !== 4'b1101)
      $display("FAIL fill_push got %b want 1101", {fifo_push_lookup, fifo_push_proc, wr_en_buf, busy}); else n_pass++;
    cyc(); smp();
    n_checks++; if ({fifo_push_lookup, fifo_push_proc, busy} !== 3'b000)
      $display("FAIL fill_done got %b want 000", {fifo_push_lookup, fifo_push_proc, busy}); else n_pass++;
  endtask

  task automatic test_no_look();
    cyc(); req_valid = 1'b1; req_look = 1'b0;
    smp();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL nolook_ready got %b want 1", req_ready); else n_pass++;
    cyc(); smp();
    n_checks++; if ({req_ready, wr_en_buf, evict_way_wr_en} !== 3'b000)
      $display("FAIL nolook_quiet got %b want 000", {req_ready, wr_en_buf, evict_way_wr_en}); else n_pass++;
    n_checks++; if ({fifo_push_lookup, fifo_push_proc} !== 2'b11) $display("FAIL nolook_push got %b want 11", {fifo_push_lookup, fifo_push_proc}); else n_pass++;
    cyc(); req_valid = 1'b0;
    smp();
    n_checks++; if ({busy, fifo_push_lookup, fifo_push_proc} !== 3'b000)
      $display("FAIL nolook_done got %b want 000", {busy, fifo_push_lookup, fifo_push_proc}); else n_pass++;
  endtask

  task automatic test_push_hold();
    set_pattern();
    cyc(); req_valid = 1'b1; req_look = 1'b1;
    cyc(); req_valid = 1'b0;
    repeat (3) cyc();
    for (int k = 0; k < 3; k++) begin
      cyc(); fifo_full_proc = 1'b1;
      smp();
      n_checks++; if ({fifo_push_lookup, fifo_push_proc, busy} !== 3'b001)
        $display("FAIL hold_proc_full k%0d got %b want 001", k, {fifo_push_lookup, fifo_push_proc, busy}); else n_pass++;
    end
    cyc(); fifo_full_proc = 1'b0; fifo_full_lookup = 1'b1;
    smp();
    n_checks++; if ({fifo_push_lookup, fifo_push_proc} !== 2'b00) $display("FAIL hold_lookup_full got %b want 00", {fifo_push_lookup, fifo_push_proc}); else n_pass++;
    cyc(); fifo_full_lookup = 1'b0;
    smp();
    n_checks++; if ({fifo_push_lookup, fifo_push_proc} !== 2'b11) $display("FAIL hold_release got %b want 11", {fifo_push_lookup, fifo_push_proc}); else n_pass++;
    cyc(); smp();
    n_checks++; if ({fifo_push_lookup, fifo_push_proc, busy} !== 3'b000)
      $display("FAIL hold_done got %b want 000", {fifo_push_lookup, fifo_push_proc, busy}); else n_pass++;
  endtask

  task automatic test_rst_state();
    set_pattern();
    cyc(); req_valid = 1'b1; req_look = 1'b1;
    cyc(); req_valid = 1'b0;
    cyc();
    cyc(); rst_state = 1'b1;
    smp();
    n_checks++; if ({wr_en_buf, evict_way_wr_en, fifo_push_lookup, fifo_push_proc} !== 4'b0)
      $display("FAIL rs_strobes got %b want 0000", {wr_en_buf, evict_way_wr_en, fifo_push_lookup, fifo_push_proc}); else n_pass++;
    cyc(); req_valid = 1'b1;
    smp();
    n_checks++; if ({busy, req_ready, wr_en_buf, fifo_push_lookup, fifo_push_proc} !== 5'b0)
      $display("FAIL rs_blocked got %b want 00000", {busy, req_ready, wr_en_buf, fifo_push_lookup, fifo_push_proc}); else n_pass++;
    cyc(); rst_state = 1'b0;
    smp();
    n_checks++; if (req_ready !== 1'b1) $display("FAIL rs_reaccept got %b want 1", req_ready); else n_pass++;
    cyc(); req_valid = 1'b0;
    smp();
    n_checks++; if ({wr_en_buf, evict_way_wr_en, way} !== 4'b1100)
      $display("FAIL rs_refill_way0 got %b want 1100", {wr_en_buf, evict_way_wr_en, way}); else n_pass++;
    n_checks++; if (state_wr_data !== 3'd0) $display("FAIL rs_refill_state got %0d want 0", state_wr_data); else n_pass++;
    repeat (3) cyc();
    cyc(); smp();
    n_checks++; if ({fifo_push_lookup, fifo_push_proc} !== 2'b11) $display("FAIL rs_refill_push got %b want 11", {fifo_push_lookup, fifo_push_proc}); else n_pass++;
    cyc(); smp();
    n_checks++; if (busy !== 1'b0) $display("FAIL rs_refill_done got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_async_reset();
    fifo_full_lookup = 1'b1;
    cyc(); req_valid = 1'b1; req_look = 1'b0;
    cyc(); req_valid = 1'b0;
    smp();
    n_checks++; if ({busy, fifo_push_lookup, fifo_push_proc} !== 3'b100)
      $display("FAIL ar_hold got %b want 100", {busy, fifo_push_lookup, fifo_push_proc}); else n_pass++;
    cyc(); req_valid = 1'b1;
    #1 rst = 1'b0;
    #1;
    n_checks++; if ({busy, req_ready, wr_en_buf, fifo_push_lookup, fifo_push_proc} !== 5'b0)
      $display("FAIL ar_outputs got %b want 00000", {busy, req_ready, wr_en_buf, fifo_push_lookup, fifo_push_proc}); else n_pass++;
    n_checks++; if ({tag_wr_data, way, evict_way_wr_data} !== '0)
      $display("FAIL ar_data got %h/%h/%h want 0", tag_wr_data, way, evict_way_wr_data); else n_pass++;
    fifo_full_lookup = 1'b0;
    #1;
    n_checks++; if ({fifo_push_lookup, fifo_push_proc} !== 2'b00) $display("FAIL ar_push_in_reset got %b want 00", {fifo_push_lookup, fifo_push_proc}); else n_pass++;
    req_valid = 1'b0;
    smp(); rst = 1'b1;
    cyc(); smp();
    n_checks++; if ({busy, fifo_push_lookup, fifo_push_proc} !== 3'b000)
      $display("FAIL ar_release got %b want 000", {busy, fifo_push_lookup, fifo_push_proc}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_fill();
    test_no_look();
    test_push_hold();
    test_rst_state();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
